// File: rtl/alu_arbiter_pkg.sv
// Shared constants for the ALU arbiter: XLEN, ALU op codes and requester port indices.
package alu_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LSL = 4'd5,
    ALU_LSR = 4'd6,
    ALU_ASR = 4'd7,
    ALU_LT  = 4'd8,
    ALU_LTU = 4'd9
  } alu_op_e;

  localparam int ARB_P_EXEC = 0;
  localparam int ARB_P_BRU  = 1;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU shared by the execute datapath and the branch/address unit.
import alu_arbiter_pkg::*;

module alu (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] in_0,
  input  logic [XLEN-1:0] in_1,
  output logic [XLEN-1:0] out
);

  // Shifts use the full in_1 value, so amounts of XLEN or more flush (or sign-fill for ASR).
  always_comb begin
    out = '0;
    case (op)
      ALU_ADD: out = in_0 + in_1;
      ALU_SUB: out = in_0 - in_1;
      ALU_AND: out = in_0 & in_1;
      ALU_OR:  out = in_0 | in_1;
      ALU_XOR: out = in_0 ^ in_1;
      ALU_LSL: out = in_0 << in_1;
      ALU_LSR: out = in_0 >> in_1;
      ALU_ASR: out = $unsigned($signed(in_0) >>> in_1);
      ALU_LT:  out = {{(XLEN-1){1'b0}}, $signed(in_0) < $signed(in_1)};
      ALU_LTU: out = {{(XLEN-1){1'b0}}, in_0 < in_1};
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Two-input round-robin picker: a lone eligible port wins, a conflict goes to the port not granted last.
import alu_arbiter_pkg::*;

module alu_rr_pick (
  input  logic [1:0] eligible,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (eligible[ARB_P_EXEC] && eligible[ARB_P_BRU]) begin
      if (last_grant) grant[ARB_P_EXEC] = 1'b1;
      else            grant[ARB_P_BRU]  = 1'b1;
    end else begin
      grant = eligible;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters with one-entry response buffers.
// Optional per-port saturating stall counters are built when ALU_ARB_STALL_CNT_EN is defined.
import alu_arbiter_pkg::*;

module alu_arbiter #(
  parameter int NPORTS = 2
`ifdef ALU_ARB_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS-1:0]            req_valid,
  output logic [NPORTS-1:0]            req_ready,
  input  logic [NPORTS-1:0][3:0]       req_op,
  input  logic [NPORTS-1:0][XLEN-1:0]  req_a,
  input  logic [NPORTS-1:0][XLEN-1:0]  req_b,
  output logic [NPORTS-1:0]            rsp_valid,
  input  logic [NPORTS-1:0]            rsp_ready,
  output logic [NPORTS-1:0][XLEN-1:0]  rsp_data
`ifdef ALU_ARB_STALL_CNT_EN
  , output logic [NPORTS-1:0][CNT_W-1:0] stall_cnt
`endif
);

  logic [NPORTS-1:0] eligible;
  logic [NPORTS-1:0] grant;
  logic              last_grant;
  logic              sel;
  logic [XLEN-1:0]   alu_out;

  // A slot that is draining this cycle may be refilled, hence the rsp_ready term.
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NPORTS; p++) begin
      eligible[p] = rst_n && req_valid[p] && (!rsp_valid[p] || rsp_ready[p]);
    end
  end

  alu_rr_pick u_pick (
    .eligible   (eligible),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = grant;
  assign sel       = grant[ARB_P_BRU];

  alu u_alu (
    .op   (req_op[sel]),
    .in_0 (req_a[sel]),
    .in_1 (req_b[sel]),
    .out  (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= '0;
      rsp_data   <= '0;
      last_grant <= 1'b1;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (grant[p]) begin
          rsp_data[p]  <= alu_out;
          rsp_valid[p] <= 1'b1;
        end else if (rsp_ready[p]) begin
          rsp_valid[p] <= 1'b0;
        end
      end
      if (|grant) last_grant <= sel;
    end
  end

`ifdef ALU_ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (req_valid[p] && !req_ready[p] && (stall_cnt[p] != {CNT_W{1'b1}})) begin
          stall_cnt[p] <= stall_cnt[p] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter; stall-counter steps are built only with ALU_ARB_STALL_CNT_EN.
import alu_arbiter_pkg::*;

module tb_alu_arbiter;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_op;
  logic [1:0][31:0]  req_a;
  logic [1:0][31:0]  req_b;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][31:0]  rsp_data;
`ifdef ALU_ARB_STALL_CNT_EN
  logic [1:0][3:0]   stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  alu_arbiter #(
    .NPORTS (2)
`ifdef ALU_ARB_STALL_CNT_EN
    , .CNT_W (4)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
`ifdef ALU_ARB_STALL_CNT_EN
    , .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                               input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                               input logic [1:0] rr);
    req_valid = v;
    req_op[0] = op0; req_a[0] = a0; req_b[0] = b0;
    req_op[1] = op1; req_a[1] = a1; req_b[1] = b1;
    rsp_ready = rr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(2'b00, ALU_ADD, 0, 0, ALU_ADD, 0, 0, 2'b11);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(2'b11, ALU_ADD, 1, 2, ALU_ADD, 3, 4, 2'b11);
    tick();
    checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_data0", rsp_data[0], 32'd0);
    checkOutput("reset_rsp_data1", rsp_data[1], 32'd0);
`ifdef ALU_ARB_STALL_CNT_EN
    checkOutput("reset_stall_cnt1", 32'(stall_cnt[1]), 32'd0);
`endif
    idle();
    #2 rst_n = 1'b1;

    $display("[TB] single request");
    tick();
    applyStimulus(2'b01, ALU_ADD, 5, 7, ALU_ADD, 0, 0, 2'b11);
    checkOutput("single_req_ready", 32'(req_ready), 32'b01);
    tick();
    idle();
    checkOutput("single_rsp_valid", 32'(rsp_valid), 32'b01);
    checkOutput("single_rsp_data0", rsp_data[0], 32'd12);
    tick();
    checkOutput("single_drain", 32'(rsp_valid), 32'b00);

    $display("[TB] conflict and alternation");
    doReset();
    applyStimulus(2'b11, ALU_SUB, 12, 4, ALU_XOR, 5, 6, 2'b11);
    checkOutput("conf_first_grant", 32'(req_ready), 32'b01);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("conf_rsp_valid", 32'(rsp_valid), (k % 2 == 1) ? 32'b01 : 32'b10);
      checkOutput("conf_next_grant", 32'(req_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
      checkOutput("conf_data0", rsp_data[0], 32'd8);
      if (k >= 2) checkOutput("conf_data1", rsp_data[1], 32'd3);
    end
    idle();
    tick();

    $display("[TB] backpressure");
    applyStimulus(2'b01, ALU_LSL, 5, 3, ALU_ADD, 0, 0, 2'b11);
    checkOutput("bp_p0_grant", 32'(req_ready), 32'b01);
    tick();
    checkOutput("bp_data0", rsp_data[0], 32'd40);
    applyStimulus(2'b11, ALU_ADD, 1, 1, ALU_ASR, 32'hFFFF_FFFF, 37, 2'b10);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_ready_p1_only", 32'(req_ready), 32'b10);
      tick();
      checkOutput("bp_hold_data0", rsp_data[0], 32'd40);
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'b11);
      checkOutput("bp_asr_data1", rsp_data[1], 32'hFFFF_FFFF);
    end
    applyStimulus(2'b11, ALU_ADD, 1, 1, ALU_ASR, 32'hFFFF_FFFF, 37, 2'b11);
    checkOutput("bp_regrant_p0", 32'(req_ready), 32'b01);
    tick();
    idle();
    checkOutput("bp_new_data0", rsp_data[0], 32'd2);
    checkOutput("bp_after_valid", 32'(rsp_valid), 32'b01);
    tick();

    $display("[TB] signed and unsigned ops");
    applyStimulus(2'b10, ALU_ADD, 0, 0, ALU_LT, 32'hFFFF_FFF6, 3, 2'b11);
    checkOutput("lt_grant", 32'(req_ready), 32'b10);
    tick();
    checkOutput("lt_data1", rsp_data[1], 32'd1);
    applyStimulus(2'b10, ALU_ADD, 0, 0, ALU_LTU, 32'hFFFF_FFF6, 3, 2'b11);
    checkOutput("ltu_grant", 32'(req_ready), 32'b10);
    tick();
    checkOutput("ltu_valid", 32'(rsp_valid), 32'b10);
    checkOutput("ltu_data1", rsp_data[1], 32'd0);
    applyStimulus(2'b01, ALU_ASR, 32'h7FFF_FFFF, 30, ALU_ADD, 0, 0, 2'b11);
    tick();
    idle();
    checkOutput("asr_valid", 32'(rsp_valid), 32'b01);
    checkOutput("asr_data0", rsp_data[0], 32'd1);
    tick();

    $display("[TB] reset mid-operation");
    applyStimulus(2'b01, ALU_ADD, 1, 2, ALU_ADD, 0, 0, 2'b11);
    tick();
    idle();
    checkOutput("mid_pre_valid", 32'(rsp_valid), 32'b01);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_async_valid", 32'(rsp_valid), 32'b00);
    checkOutput("mid_async_data0", rsp_data[0], 32'd0);
    tick();
    #2 rst_n = 1'b1;
    applyStimulus(2'b11, ALU_ADD, 1, 1, ALU_ADD, 2, 2, 2'b11);
    checkOutput("mid_first_conflict", 32'(req_ready), 32'b01);
    tick();
    idle();
    checkOutput("mid_data0", rsp_data[0], 32'd2);
    tick();

`ifdef ALU_ARB_STALL_CNT_EN
    $display("[TB] stall counters");
    doReset();
    applyStimulus(2'b10, ALU_ADD, 0, 0, ALU_ADD, 9, 9, 2'b01);
    checkOutput("stall_p1_fill", 32'(req_ready), 32'b10);
    tick();
    applyStimulus(2'b11, ALU_ADD, 1, 1, ALU_ADD, 9, 9, 2'b01);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("stall_cnt1_5", 32'(stall_cnt[1]), 32'd5);
    checkOutput("stall_cnt0_0", 32'(stall_cnt[0]), 32'd0);
    for (int k = 0; k < 15; k++) tick();
    checkOutput("stall_cnt1_sat", 32'(stall_cnt[1]), 32'd15);
    for (int k = 0; k < 3; k++) tick();
    checkOutput("stall_cnt1_hold", 32'(stall_cnt[1]), 32'd15);
    idle();
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
